traffic_intersection_fsm: RTL and testbench
===========================================

Name: traffic_intersection_fsm

Overview:
- Parametrised two-approach intersection controller: north-south (NS) and east-west (EW) signal heads, all-red clearance and a latched pedestrian walk phase.
- Adds a flashing-yellow fallback mode.
- All phase durations are counted in `tick` strobes, so a shared prescaler can drive several controllers.
- Instantiated per junction under the top-level signal controller.

Parameters:
- TIMER_W, 8, phase timer width in bits.
- GREEN_TICKS, 30, green duration per approach, in ticks.
- YELLOW_TICKS, 10, yellow duration per approach, in ticks.
- ALLRED_TICKS, 5, all-red clearance duration, in ticks.
- PED_TICKS, 20, pedestrian walk duration, in ticks.
- FLASH_TICKS, 4, half-period of flashing yellow, in ticks.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  0 forces OFF; 1 runs the controller.
- flash  in  1  1 selects flashing-yellow mode (only when enable=1).
- tick  in  1  timebase strobe; tie to 1 to count cycles.
- ped_req  in  1  pedestrian request pulse or level.
- light_ns  out  2  NS head: 0=OFF, 1=RED, 2=YELLOW, 3=GREEN.
- light_ew  out  2  EW head, same encoding.
- ped_walk  out  1  walk indication.
- ped_pending  out  1  a latched request is waiting.
- phase  out  4  current state code, for debug and bench.

Behaviour:
- States and phase codes: OFF=0, FLASH=1, ALLRED_A=2, PED_A=3, NS_G=4, NS_Y=5, ALLRED_B=6, PED_B=7, EW_G=8, EW_Y=9. Codes 10-15 are unreachable; if entered, the next cycle goes to OFF.
- Outputs (Moore: decoded from the state register, ped_pending is itself a register):
  - OFF: both lights OFF.
  - FLASH: both lights YELLOW when flash_on=1, else OFF.
  - ALLRED_A, ALLRED_B, PED_A, PED_B: both lights RED.
  - NS_G / NS_Y: NS GREEN / YELLOW, EW RED.
  - EW_G / EW_Y: EW GREEN / YELLOW, NS RED.
  - ped_walk=1 only in PED_A and PED_B.
- Reset (rst=1 at edge): state=OFF, timer=0, ped_pending=0, flash_on=0. All outputs therefore read 0 the next cycle. Reset overrides all other inputs, including mid-phase.
- Priority at each edge: rst > enable=0 > flash > timed sequence.
- enable=0: next state OFF, timer=0, ped_pending cleared, from any state.
- OFF with enable=1:
  - flash=1: go to FLASH.
  - flash=0: go to ALLRED_A. Start-up always begins with all-red clearance.
- Timer, in timed states:
  - Cleared to 0 on every state entry.
  - On a cycle with tick=1: if timer==DUR-1, the state advances and timer<=0; otherwise timer<=timer+1.
  - tick=0 holds timer and state.
  - Each timed state therefore lasts exactly DUR ticks. Duration per state: GREEN_TICKS for NS_G/EW_G, YELLOW_TICKS for NS_Y/EW_Y, ALLRED_TICKS for ALLRED_A/B, PED_TICKS for PED_A/B.
- Sequence: ALLRED_A -> [PED_A] -> NS_G -> NS_Y -> ALLRED_B -> [PED_B] -> EW_G -> EW_Y -> ALLRED_A.
- Pedestrian handling:
  - On expiry of ALLRED_A/B, take PED_A/B if (ped_pending | ped_req)=1; otherwise take the green.
  - PED_A exits to NS_G; PED_B exits to EW_G.
  - ped_pending is set by ped_req in any timed state except PED_A/B.
  - ped_pending is cleared on entry to PED_A/B.
  - ped_req asserted while in PED_A/B is ignored.
  - A request in the same cycle as PED entry is consumed, not re-latched.
- Flash mode:
  - Entering FLASH sets flash_on=1 and timer=0.
  - Every FLASH_TICKS ticks, flash_on toggles and timer=0.
  - From any timed state, flash=1 moves to FLASH next cycle; ped_pending is kept.
  - flash=0 while in FLASH moves to ALLRED_A.
- Arithmetic: timer is unsigned TIMER_W bits and never wraps, because it clears at DUR-1.
- Every *_TICKS must satisfy 1 <= value <= 2^TIMER_W. A violation is an elaboration-time $error.

Test Plan:
(params GREEN=5, YELLOW=2, ALLRED=1, PED=3, FLASH=2, tick=1 unless stated)
- rst=1 for 2 cycles, then enable=1, flash=0 -> phase 0 -> 2 for 1 cycle -> 4 for 5 cycles -> 5 for 2 -> 6 for 1 -> 8 for 5 -> 9 for 2 -> back to 2. Light values checked every cycle.
- ped_req 1-cycle pulse during NS_G -> ped_pending=1 through NS_Y and ALLRED_B -> PED_B for 3 cycles with both lights RED and ped_walk=1, ped_pending=0 -> EW_G.
- ped_req held high during PED_A -> ped_pending stays 0. The next ALLRED_B is not followed by PED_B unless ped_req is still high at ALLRED_B expiry.
- flash=1 during EW_G -> FLASH next cycle, both lights YELLOW 2 cycles, OFF 2 cycles, repeating. flash=0 -> ALLRED_A then NS_G.
- tick strobed every 3rd cycle -> NS_G lasts 15 cycles. tick=0 for 10 cycles mid-green -> state and timer frozen.
- enable=0 mid-NS_Y, and separately rst=1 mid-PED_A -> OFF next cycle, lights 0, ped_walk=0, ped_pending=0, timer=0. Re-enable -> ALLRED_A.

Source files
------------

// File: rtl/traffic_intersection_fsm.sv
// Two-approach intersection controller: NS/EW heads, all-red clearance, latched
// pedestrian walk phase and a flashing-yellow fallback, all timed in tick strobes.
module traffic_intersection_fsm #(
  parameter int TIMER_W      = 8,
  parameter int GREEN_TICKS  = 30,
  parameter int YELLOW_TICKS = 10,
  parameter int ALLRED_TICKS = 5,
  parameter int PED_TICKS    = 20,
  parameter int FLASH_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       flash,
  input  logic       tick,
  input  logic       ped_req,
  output logic [1:0] light_ns,
  output logic [1:0] light_ew,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [3:0] phase
);

  // state    | meaning
  // OFF      | disabled, both heads dark
  // FLASH    | flashing yellow, flash_on selects lit/dark half-period
  // ALLRED_A | clearance before NS green
  // PED_A    | walk phase before NS green
  // NS_G     | NS green
  // NS_Y     | NS yellow
  // ALLRED_B | clearance before EW green
  // PED_B    | walk phase before EW green
  // EW_G     | EW green
  // EW_Y     | EW yellow
  typedef enum logic [3:0] {
    S_OFF      = 4'd0,
    S_FLASH    = 4'd1,
    S_ALLRED_A = 4'd2,
    S_PED_A    = 4'd3,
    S_NS_G     = 4'd4,
    S_NS_Y     = 4'd5,
    S_ALLRED_B = 4'd6,
    S_PED_B    = 4'd7,
    S_EW_G     = 4'd8,
    S_EW_Y     = 4'd9
  } state_t;

  localparam logic [1:0] L_OFF = 2'd0;
  localparam logic [1:0] L_RED = 2'd1;
  localparam logic [1:0] L_YEL = 2'd2;
  localparam logic [1:0] L_GRN = 2'd3;

  localparam longint TICK_MAX = longint'(1) << TIMER_W;

  if (GREEN_TICKS < 1 || longint'(GREEN_TICKS) > TICK_MAX ||
      YELLOW_TICKS < 1 || longint'(YELLOW_TICKS) > TICK_MAX ||
      ALLRED_TICKS < 1 || longint'(ALLRED_TICKS) > TICK_MAX ||
      PED_TICKS < 1 || longint'(PED_TICKS) > TICK_MAX ||
      FLASH_TICKS < 1 || longint'(FLASH_TICKS) > TICK_MAX) begin : g_bad_ticks
    $error("traffic_intersection_fsm: every *_TICKS must lie in 1..2^TIMER_W");
  end

  // Terminal counts: the timer counts up from 0 and the state advances at DUR-1.
  localparam logic [TIMER_W-1:0] GREEN_LAST  = TIMER_W'(GREEN_TICKS - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_TICKS - 1);
  localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALLRED_TICKS - 1);
  localparam logic [TIMER_W-1:0] PED_LAST    = TIMER_W'(PED_TICKS - 1);
  localparam logic [TIMER_W-1:0] FLASH_LAST  = TIMER_W'(FLASH_TICKS - 1);

  state_t               state, state_n, seq_n;
  logic [TIMER_W-1:0]   timer, timer_n, last;
  logic                 pend_n, flash_on, flash_on_n;
  logic                 timed, in_ped, want_ped;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_OFF;
      timer       <= '0;
      ped_pending <= 1'b0;
      flash_on    <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      ped_pending <= pend_n;
      flash_on    <= flash_on_n;
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    pend_n     = ped_pending;
    flash_on_n = flash_on;
    last       = '0;
    seq_n      = S_OFF;
    timed      = 1'b1;
    in_ped     = 1'b0;
    want_ped   = ped_pending | ped_req;

    case (state)
      S_ALLRED_A: begin last = ALLRED_LAST; seq_n = want_ped ? S_PED_A : S_NS_G; end
      S_PED_A:    begin last = PED_LAST;    seq_n = S_NS_G; in_ped = 1'b1; end
      S_NS_G:     begin last = GREEN_LAST;  seq_n = S_NS_Y; end
      S_NS_Y:     begin last = YELLOW_LAST; seq_n = S_ALLRED_B; end
      S_ALLRED_B: begin last = ALLRED_LAST; seq_n = want_ped ? S_PED_B : S_EW_G; end
      S_PED_B:    begin last = PED_LAST;    seq_n = S_EW_G; in_ped = 1'b1; end
      S_EW_G:     begin last = GREEN_LAST;  seq_n = S_EW_Y; end
      S_EW_Y:     begin last = YELLOW_LAST; seq_n = S_ALLRED_A; end
      default:    timed = 1'b0;
    endcase

    if (!enable) begin
      state_n    = S_OFF;
      timer_n    = '0;
      pend_n     = 1'b0;
      flash_on_n = 1'b0;
    end else if (state == S_OFF) begin
      timer_n = '0;
      if (flash) begin
        state_n    = S_FLASH;
        flash_on_n = 1'b1;
      end else begin
        state_n = S_ALLRED_A;
      end
    end else if (state == S_FLASH) begin
      if (!flash) begin
        state_n    = S_ALLRED_A;
        timer_n    = '0;
        flash_on_n = 1'b0;
      end else if (tick) begin
        if (timer == FLASH_LAST) begin
          timer_n    = '0;
          flash_on_n = ~flash_on;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end
    end else if (timed) begin
      if (ped_req && !in_ped) pend_n = 1'b1;
      if (flash) begin
        state_n    = S_FLASH;
        timer_n    = '0;
        flash_on_n = 1'b1;
      end else if (tick) begin
        if (timer == last) begin
          state_n = seq_n;
          timer_n = '0;
          // Entering a walk phase consumes the request, including one arriving this cycle.
          if (seq_n == S_PED_A || seq_n == S_PED_B) pend_n = 1'b0;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end
    end else begin
      state_n    = S_OFF;
      timer_n    = '0;
      pend_n     = 1'b0;
      flash_on_n = 1'b0;
    end
  end

  always_comb begin
    light_ns = L_OFF;
    light_ew = L_OFF;
    ped_walk = 1'b0;
    case (state)
      S_FLASH: begin
        light_ns = flash_on ? L_YEL : L_OFF;
        light_ew = flash_on ? L_YEL : L_OFF;
      end
      S_ALLRED_A, S_ALLRED_B: begin light_ns = L_RED; light_ew = L_RED; end
      S_PED_A, S_PED_B: begin light_ns = L_RED; light_ew = L_RED; ped_walk = 1'b1; end
      S_NS_G: begin light_ns = L_GRN; light_ew = L_RED; end
      S_NS_Y: begin light_ns = L_YEL; light_ew = L_RED; end
      S_EW_G: begin light_ns = L_RED; light_ew = L_GRN; end
      S_EW_Y: begin light_ns = L_RED; light_ew = L_YEL; end
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_intersection_fsm.sv
// Bench for traffic_intersection_fsm: fixed vector table, directed corner sequences
// and random stimulus checked against a remaining-ticks reference model.
module tb_traffic_intersection_fsm;
  localparam int GREEN = 5, YELLOW = 2, ALLRED = 1, PED = 3, FLASHT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1, enable = 1'b0, flash = 1'b0, tick = 1'b1, ped_req = 1'b0;
  logic [1:0] light_ns, light_ew;
  logic       ped_walk, ped_pending;
  logic [3:0] phase;

  int checks = 0;
  int errors = 0;

  // Reference model: phase code, ticks left in the phase, latched request, flash lamp.
  int m_phase = 0, m_left = 0;
  bit m_pend = 0, m_fon = 0;

  typedef struct {
    bit rst, en, fl, tk, pr;
    int ph, ns, ew;
  } vec_t;
  vec_t vq[$];

  traffic_intersection_fsm #(
    .TIMER_W(8), .GREEN_TICKS(GREEN), .YELLOW_TICKS(YELLOW),
    .ALLRED_TICKS(ALLRED), .PED_TICKS(PED), .FLASH_TICKS(FLASHT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .flash(flash), .tick(tick),
    .ped_req(ped_req), .light_ns(light_ns), .light_ew(light_ew),
    .ped_walk(ped_walk), .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dur_of(input int p);
    case (p)
      2, 6:    return ALLRED;
      3, 7:    return PED;
      4, 8:    return GREEN;
      5, 9:    return YELLOW;
      default: return 0;
    endcase
  endfunction

  function automatic int next_of(input int p, input bit want_ped);
    case (p)
      2:       return want_ped ? 3 : 4;
      3:       return 4;
      4:       return 5;
      5:       return 6;
      6:       return want_ped ? 7 : 8;
      7:       return 8;
      8:       return 9;
      default: return 2;
    endcase
  endfunction

  function automatic int exp_ns(input int p, input bit fon);
    case (p)
      1:             return fon ? 2 : 0;
      2, 3, 6, 7:    return 1;
      4:             return 3;
      5:             return 2;
      8, 9:          return 1;
      default:       return 0;
    endcase
  endfunction

  function automatic int exp_ew(input int p, input bit fon);
    case (p)
      1:             return fon ? 2 : 0;
      2, 3, 6, 7:    return 1;
      4, 5:          return 1;
      8:             return 3;
      9:             return 2;
      default:       return 0;
    endcase
  endfunction

  task automatic model_step();
    bit in_ped;
    int nxt;
    in_ped = (m_phase == 3 || m_phase == 7);
    if (rst || !enable) begin
      m_phase = 0; m_left = 0; m_pend = 0; m_fon = 0;
    end else if (m_phase == 0) begin
      if (flash) begin m_phase = 1; m_fon = 1; m_left = FLASHT; end
      else begin m_phase = 2; m_left = dur_of(2); end
    end else if (m_phase == 1) begin
      if (!flash) begin m_phase = 2; m_left = dur_of(2); end
      else if (tick) begin
        m_left--;
        if (m_left == 0) begin m_fon = !m_fon; m_left = FLASHT; end
      end
    end else begin
      if (ped_req && !in_ped) m_pend = 1;
      if (flash) begin m_phase = 1; m_fon = 1; m_left = FLASHT; end
      else if (tick) begin
        m_left--;
        if (m_left == 0) begin
          nxt = next_of(m_phase, m_pend);
          if (nxt == 3 || nxt == 7) m_pend = 0;
          m_phase = nxt;
          m_left = dur_of(nxt);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("phase", int'(phase), m_phase);
    chk("light_ns", int'(light_ns), exp_ns(m_phase, m_fon));
    chk("light_ew", int'(light_ew), exp_ew(m_phase, m_fon));
    chk("ped_walk", int'(ped_walk), (m_phase == 3 || m_phase == 7) ? 1 : 0);
    chk("ped_pending", int'(ped_pending), int'(m_pend));
  endtask

  task automatic run_until(input int target, input int limit);
    bit found;
    found = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (int'(phase) == target) begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL run_until: phase %0d, required %0d within %0d cycles", phase, target, limit);
    end
  endtask

  task automatic add(input bit r, input bit e, input int ph, input int ns, input int ew);
    vec_t v;
    v.rst = r; v.en = e; v.fl = 0; v.tk = 1; v.pr = 0;
    v.ph = ph; v.ns = ns; v.ew = ew;
    vq.push_back(v);
  endtask

  // Counts cycles spent in NS_G from its entry cycle under a tick schedule.
  task automatic measure_green(input int mode, output int cnt);
    cnt = 1;
    for (int k = 1; k < 100; k++) begin
      tick = (mode == 0) ? (k % 3 == 0) : !(k >= 3 && k <= 12);
      step();
      if (int'(phase) != 4) break;
      cnt++;
    end
    tick = 1;
  endtask

  initial begin
    int n;
    bit saw7;

    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    add(0, 1, 2, 1, 1);
    repeat (5) add(0, 1, 4, 3, 1);
    repeat (2) add(0, 1, 5, 2, 1);
    add(0, 1, 6, 1, 1);
    repeat (5) add(0, 1, 8, 1, 3);
    repeat (2) add(0, 1, 9, 1, 2);
    add(0, 1, 2, 1, 1);

    foreach (vq[i]) begin
      rst = vq[i].rst; enable = vq[i].en; flash = vq[i].fl;
      tick = vq[i].tk; ped_req = vq[i].pr;
      step();
      chk("tbl_phase", int'(phase), vq[i].ph);
      chk("tbl_ns", int'(light_ns), vq[i].ns);
      chk("tbl_ew", int'(light_ew), vq[i].ew);
    end

    // Request pulse during NS_G is served by PED_B.
    run_until(4, 20);
    ped_req = 1; step(); ped_req = 0;
    chk("pend_after_pulse", int'(ped_pending), 1);
    run_until(6, 20);
    chk("pend_in_allred_b", int'(ped_pending), 1);
    step();
    chk("enter_ped_b", int'(phase), 7);
    chk("walk_ped_b", int'(ped_walk), 1);
    chk("pend_cleared", int'(ped_pending), 0);
    n = 1;
    while (int'(phase) == 7 && n < 10) begin
      step();
      if (int'(phase) == 7) n++;
    end
    chk("ped_b_len", n, PED);
    chk("after_ped_b", int'(phase), 8);

    // Request held through PED_A is not re-latched.
    run_until(2, 40);
    ped_req = 1; step();
    chk("enter_ped_a", int'(phase), 3);
    step(); chk("pend_hold_a1", int'(ped_pending), 0);
    step(); chk("pend_hold_a2", int'(ped_pending), 0);
    step(); chk("ped_a_exit", int'(phase), 4);
    chk("pend_hold_a3", int'(ped_pending), 0);
    ped_req = 0;
    saw7 = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (int'(phase) == 7) saw7 = 1;
      if (int'(phase) == 8) break;
    end
    chk("no_ped_b", int'(saw7), 0);

    // Flash from EW_G: yellow 2 cycles, dark 2 cycles, repeating.
    flash = 1; step();
    chk("flash_enter", int'(phase), 1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      chk("flash_pat_ns", int'(light_ns), ((k / 2) % 2 == 0) ? 2 : 0);
      chk("flash_pat_ew", int'(light_ew), ((k / 2) % 2 == 0) ? 2 : 0);
    end
    flash = 0; step();
    chk("flash_exit", int'(phase), 2);
    step();
    chk("flash_to_ns_g", int'(phase), 4);

    measure_green(0, n);
    chk("green_tick3_len", n, 3 * GREEN);
    run_until(4, 60);
    measure_green(1, n);
    chk("green_frozen_len", n, GREEN + 10);

    // enable=0 mid NS_Y with a pending request.
    run_until(4, 60);
    ped_req = 1; step(); ped_req = 0;
    run_until(5, 20);
    chk("pend_before_off", int'(ped_pending), 1);
    enable = 0; step();
    chk("off_phase", int'(phase), 0);
    chk("off_ns", int'(light_ns), 0);
    chk("off_ew", int'(light_ew), 0);
    chk("off_pend", int'(ped_pending), 0);
    step();
    enable = 1; step();
    chk("reenable", int'(phase), 2);

    // Reset mid PED_A.
    ped_req = 1; step(); ped_req = 0;
    chk("ped_a_again", int'(phase), 3);
    step();
    rst = 1; step();
    chk("rst_phase", int'(phase), 0);
    chk("rst_walk", int'(ped_walk), 0);
    chk("rst_pend", int'(ped_pending), 0);
    rst = 0; step();
    chk("after_rst", int'(phase), 2);

    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      enable  = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 39) == 0) flash = !flash;
      tick    = ($urandom_range(0, 3) != 0);
      ped_req = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
